// File: rtl/fifo_rd_arbiter_2to1.sv
// fifo_rd_arbiter_2to1: read-side scheduler for two FIFOs sharing one 2:1 mux.
// It arbitrates round-robin with a burst limit, or serves a single port
// selected by mode. It issues the pop strobes combinationally and captures the
// selected word into a registered ready/valid output stage.
module fifo_rd_arbiter_2to1 #(
  parameter int bw    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          empty0,
  input  logic          empty1,
  input  logic [bw-1:0] in0,
  input  logic [bw-1:0] in1,
  input  logic [1:0]    mode,
  input  logic          out_ready,
  output logic          rd0,
  output logic          rd1,
  output logic          sel,
  output logic [bw-1:0] out,
  output logic          out_valid
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_oth_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic [bw-1:0] r_out;
  logic          r_out_valid;

  logic w_req0;
  logic w_req1;
  logic w_freeze;
  logic w_can_pop;
  logic w_pop;
  logic w_req_cur;
  logic w_req_oth;
  logic w_oth_port;

  assign out       = r_out;
  assign out_valid = r_out_valid;

  // Qualify requests by mode and derive the pop strobes and mux select
  always_comb begin
    w_freeze  = (mode == 2'b11);
    w_req0    = !empty0 && ((mode == 2'b00) || (mode == 2'b01));
    w_req1    = !empty1 && ((mode == 2'b00) || (mode == 2'b10));
    w_can_pop = !r_out_valid || out_ready;
    sel       = (r_state == GRANT1);
    rd0       = (r_state == GRANT0) && w_req0 && w_can_pop;
    rd1       = (r_state == GRANT1) && w_req1 && w_can_pop;
    w_pop     = rd0 || rd1;
  end

  // Next-state logic: arbitration from IDLE, burst counting and direct switching between grants
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_req_cur   = sel ? w_req1 : w_req0;
    w_req_oth   = sel ? w_req0 : w_req1;
    w_oth_port  = !sel;
    w_oth_state = sel ? GRANT0 : GRANT1;
    // Freeze holds the whole arbiter context so a later resume continues the burst
    if (!w_freeze) begin
      if (r_state == IDLE) begin
        // A tie goes to the port that was not granted last
        if (w_req0 && (!w_req1 || r_last)) begin
          w_state_nxt = GRANT0;
          w_cnt_nxt   = '0;
          w_last_nxt  = 1'b0;
        end else if (w_req1) begin
          w_state_nxt = GRANT1;
          w_cnt_nxt   = '0;
          w_last_nxt  = 1'b1;
        end
      end else if (!w_req_cur) begin
        // Current port dried up or was masked: hand over directly, no bubble
        w_cnt_nxt = '0;
        if (w_req_oth) begin
          w_state_nxt = w_oth_state;
          w_last_nxt  = w_oth_port;
        end else begin
          w_state_nxt = IDLE;
        end
      end else if (w_pop) begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_req_oth) begin
            w_state_nxt = w_oth_state;
            w_last_nxt  = w_oth_port;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Output stage: capture the popped word, otherwise drain on out_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out       <= sel ? in1 : in0;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
